ppgen_stage: RTL and testbench

//   Partial-product generation stage for the 8x8 unsigned approximate multiplier.
//   - Accepts operand pairs over a valid/ready handshake.
//   - Forms the W*W AND-array partial products and registers them.
//   - Presents them, flat and row-major, to the downstream compressor tree (ppcom).
//   - A 2-entry skid buffer gives full throughput with registered in_ready.

---
 rtl/mult_pkg.sv | 17 +
 rtl/ppgen_stage_if.sv | 31 +++
 rtl/ppgen_stage_pp_and_array.sv | 26 ++
 rtl/ppgen_stage.sv | 117 +++++++++++
 tb/tb_ppgen_stage.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared types and widths for the 8x8 approximate multiplier datapath.
// Used by the partial-product stage and its compressor tree.
package mult_pkg;

    localparam int OP_W   = 8;
    localparam int TAG_DW = 4;
    localparam int PP_W   = OP_W * OP_W;

    typedef logic [OP_W-1:0] pp_row_t;

    typedef struct packed {
        logic [OP_W-1:0]   a;
        logic [OP_W-1:0]   b;
        logic [TAG_DW-1:0] tag;
    } op_pair_t;

endpackage

// File: rtl/ppgen_stage_if.sv
// Operand-in / partial-product-out handshake bundle for ppgen_stage.
// master drives operands and out_ready; slave is the stage itself.
interface ppgen_stage_if
    import mult_pkg::*;
#(
    parameter int W     = OP_W,
    parameter int TAG_W = TAG_DW
) ();

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W*W-1:0]   out_pp;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_pp, out_tag, out_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_pp, out_tag, out_zero
    );

endinterface

// File: rtl/ppgen_stage_pp_and_array.sv
// W x W AND array: pp[W*i+j] = a[j] & b[i], row i carries weight i+j.
// zero flags an exactly-zero product so later stages can skip work.
module pp_and_array
    import mult_pkg::*;
#(
    parameter int W = OP_W
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [W*W-1:0] pp,
    output logic           zero
);

    // Pure bitwise AND array, no carries.
    always_comb begin
        pp = '0;
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                pp[W*i+j] = a[j] & b[i];
            end
        end
    end

    assign zero = ~|a | ~|b;

endmodule

// File: rtl/ppgen_stage.sv
// Partial-product stage: 2-entry skid (OR + SR) with registered in_ready.
// Define PPGEN_ISOLATE_EN to zero out_pp/out_tag while out_valid is low.
module ppgen_stage
    import mult_pkg::*;
#(
    parameter int W     = OP_W,
    parameter int TAG_W = TAG_DW
) (
    input logic          clk,
    input logic          rst_n,
    ppgen_stage_if.slave bus
);

    logic             or_valid;
    logic [W*W-1:0]   or_pp;
    logic [TAG_W-1:0] or_tag;
    logic             or_zero;

    logic             sr_valid;
    logic [W-1:0]     sr_a;
    logic [W-1:0]     sr_b;
    logic [TAG_W-1:0] sr_tag;

    logic             drain;
    logic             acc;
    logic             or_free;
    logic             load_or;
    logic             load_sr;

    logic [W-1:0]     ld_a;
    logic [W-1:0]     ld_b;
    logic [TAG_W-1:0] ld_tag;
    logic [W*W-1:0]   ld_pp;
    logic             ld_zero;

    assign bus.in_ready = rst_n & ~sr_valid;

    assign drain   = or_valid & bus.out_ready;
    assign acc     = bus.in_valid & bus.in_ready;
    assign or_free = ~or_valid | drain;
    assign load_or = or_free & (sr_valid | acc);
    assign load_sr = acc & ~(or_free & ~sr_valid);

    // SR is always older than the input, so it wins the OR load.
    assign ld_a   = sr_valid ? sr_a   : bus.in_a;
    assign ld_b   = sr_valid ? sr_b   : bus.in_b;
    assign ld_tag = sr_valid ? sr_tag : bus.in_tag;

    pp_and_array #(.W(W)) u_and (
        .a    (ld_a),
        .b    (ld_b),
        .pp   (ld_pp),
        .zero (ld_zero)
    );

    // Occupancy flags: OR fills on load, SR holds overflow while OR stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            or_valid <= 1'b0;
            sr_valid <= 1'b0;
        end else begin
            if (load_or) begin
                or_valid <= 1'b1;
            end else if (drain) begin
                or_valid <= 1'b0;
            end
            if (or_free) begin
                sr_valid <= sr_valid & acc;
            end else if (acc) begin
                sr_valid <= 1'b1;
            end
        end
    end

    // Skid register keeps raw operands; pp is formed only on OR load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_a   <= '0;
            sr_b   <= '0;
            sr_tag <= '0;
        end else if (load_sr) begin
            sr_a   <= bus.in_a;
            sr_b   <= bus.in_b;
            sr_tag <= bus.in_tag;
        end
    end

    // Output register data; optionally cleared when it empties.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            or_pp   <= '0;
            or_tag  <= '0;
            or_zero <= 1'b0;
        end else if (load_or) begin
            or_pp   <= ld_pp;
            or_tag  <= ld_tag;
            or_zero <= ld_zero;
`ifdef PPGEN_ISOLATE_EN
        end else if (drain) begin
            or_pp  <= '0;
            or_tag <= '0;
`endif
        end
    end

    assign bus.out_valid = or_valid;
    assign bus.out_zero  = or_zero;

`ifdef PPGEN_ISOLATE_EN
    assign bus.out_pp  = or_valid ? or_pp  : '0;
    assign bus.out_tag = or_valid ? or_tag : '0;
`else
    assign bus.out_pp  = or_pp;
    assign bus.out_tag = or_tag;
`endif

endmodule

// File: tb/tb_ppgen_stage.sv
// Self-checking bench for ppgen_stage: directed cases plus random flow
// against a queue model (occupancy, FIFO order, a*b reconstruction).
module tb_ppgen_stage;
    import mult_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ppgen_stage_if #(.W(OP_W), .TAG_W(TAG_DW)) bus ();

    ppgen_stage #(.W(OP_W), .TAG_W(TAG_DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // Row-wise reference: row i is a copy of a when b[i] is set.
    function automatic logic [PP_W-1:0] ref_pp(logic [OP_W-1:0] a, logic [OP_W-1:0] b);
        logic [PP_W-1:0] r;
        r = '0;
        for (int i = 0; i < OP_W; i++) begin
            if (b[i]) r[OP_W*i +: OP_W] = a;
        end
        return r;
    endfunction

    // Weighted sum of the rows, should equal a*b.
    function automatic longint pp_value(logic [PP_W-1:0] pp);
        longint s;
        s = 0;
        for (int i = 0; i < OP_W; i++) begin
            s += longint'(pp[OP_W*i +: OP_W]) << i;
        end
        return s;
    endfunction

    function automatic op_pair_t rand_pair();
        op_pair_t p;
        p.a = OP_W'($urandom);
        p.b = OP_W'($urandom);
        p.tag = TAG_DW'($urandom);
        return p;
    endfunction

    task automatic drive_idle();
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_tag = '0;
        bus.out_ready = 1'b0;
    endtask

    task automatic drive_pair(op_pair_t p);
        bus.in_valid = 1'b1;
        bus.in_a = p.a;
        bus.in_b = p.b;
        bus.in_tag = p.tag;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        checks++;
        if (bus.out_pp !== '0 || bus.out_tag !== '0 || bus.out_zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got pp=%h tag=%h zero=%b want 0",
                     bus.out_pp, bus.out_tag, bus.out_zero);
        end
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_single();
        op_pair_t p;
        p.a = 8'hFF;
        p.b = 8'h01;
        p.tag = 4'd3;
        @(negedge clk);
        drive_pair(p);
        bus.out_ready = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_in_ready: got %b want 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pp !== 64'h00000000000000FF ||
            bus.out_tag !== 4'd3 || bus.out_zero !== 1'b0) begin
            failures++;
            $display("FAIL single_out: got v=%b pp=%h tag=%h z=%b want 1 00000000000000ff 3 0",
                     bus.out_valid, bus.out_pp, bus.out_tag, bus.out_zero);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_drain: got out_valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_backpressure();
        op_pair_t p [3];
        p[0].a = 8'd5; p[0].b = 8'd3; p[0].tag = 4'd1;
        p[1].a = 8'd7; p[1].b = 8'd9; p[1].tag = 4'd2;
        p[2].a = 8'd1; p[2].b = 8'd1; p[2].tag = 4'd3;
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive_pair(p[0]);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_accept0: got in_ready=%b want 1", bus.in_ready);
        end
        @(negedge clk);
        drive_pair(p[1]);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1 ||
            bus.out_pp !== ref_pp(p[0].a, p[0].b)) begin
            failures++;
            $display("FAIL bp_accept1: got rdy=%b v=%b pp=%h want 1 1 %h",
                     bus.in_ready, bus.out_valid, bus.out_pp, ref_pp(p[0].a, p[0].b));
        end
        @(negedge clk);
        drive_pair(p[2]);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_full: got in_ready=%b want 0", bus.in_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_tag !== 4'd1 ||
            bus.out_pp !== ref_pp(p[0].a, p[0].b)) begin
            failures++;
            $display("FAIL bp_hold: got rdy=%b v=%b tag=%h pp=%h want 0 1 1 %h",
                     bus.in_ready, bus.out_valid, bus.out_tag, bus.out_pp,
                     ref_pp(p[0].a, p[0].b));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_tag !== 4'd2 ||
            bus.out_pp !== ref_pp(p[1].a, p[1].b) || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_second: got v=%b tag=%h pp=%h rdy=%b want 1 2 %h 1",
                     bus.out_valid, bus.out_tag, bus.out_pp, bus.in_ready,
                     ref_pp(p[1].a, p[1].b));
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_tag !== 4'd3 ||
            bus.out_pp !== ref_pp(p[2].a, p[2].b)) begin
            failures++;
            $display("FAIL bp_third: got v=%b tag=%h pp=%h want 1 3 %h",
                     bus.out_valid, bus.out_tag, bus.out_pp, ref_pp(p[2].a, p[2].b));
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_empty: got out_valid=%b want 0", bus.out_valid);
        end
    endtask

    // Random flow against a queue model; full_rate forces valid=ready=1.
    task automatic test_flow(input bit full_rate, input int n_pairs, input string name);
        op_pair_t q [$];
        op_pair_t e;
        op_pair_t nxt;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        logic [PP_W-1:0] prev_pp = '0;
        logic [TAG_DW-1:0] prev_tag = '0;
        nxt = rand_pair();
        while (got < n_pairs && cyc < 20 * n_pairs) begin
            @(negedge clk);
            cyc++;
            bus.out_ready = full_rate ? 1'b1 : 1'(($urandom % 3) != 0);
            if (sent < n_pairs && (full_rate || ($urandom % 4) != 0)) begin
                drive_pair(nxt);
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            checks++;
            if (bus.in_ready !== (q.size() < 2) || bus.out_valid !== (q.size() > 0)) begin
                failures++;
                $display("FAIL %s_occupancy: got rdy=%b v=%b want occupancy %0d",
                         name, bus.in_ready, bus.out_valid, q.size());
            end
            if (full_rate && got > 0) begin
                checks++;
                if (bus.out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL %s_gap: got out_valid=%b want 1 at cycle %0d",
                             name, bus.out_valid, cyc);
                end
            end
            if (stalled) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_pp !== prev_pp ||
                    bus.out_tag !== prev_tag) begin
                    failures++;
                    $display("FAIL %s_stall_hold: got v=%b pp=%h tag=%h want 1 %h %h",
                             name, bus.out_valid, bus.out_pp, bus.out_tag, prev_pp, prev_tag);
                end
            end
            stalled = bus.out_valid && !bus.out_ready;
            prev_pp = bus.out_pp;
            prev_tag = bus.out_tag;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL %s_spurious: got tag=%h want no output", name, bus.out_tag);
                end else begin
                    e = q.pop_front();
                    if (bus.out_pp !== ref_pp(e.a, e.b) || bus.out_tag !== e.tag ||
                        bus.out_zero !== (e.a == 0 || e.b == 0) ||
                        pp_value(bus.out_pp) != longint'(e.a) * longint'(e.b)) begin
                        failures++;
                        $display("FAIL %s_data: got pp=%h tag=%h z=%b want a=%h b=%h tag=%h",
                                 name, bus.out_pp, bus.out_tag, bus.out_zero, e.a, e.b, e.tag);
                    end
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(nxt);
                sent++;
                nxt = rand_pair();
            end
        end
        checks++;
        if (got != n_pairs || q.size() != 0) begin
            failures++;
            $display("FAIL %s_count: got %0d outputs want %0d (left %0d)",
                     name, got, n_pairs, q.size());
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_zero();
        op_pair_t p0;
        op_pair_t p1;
        p0.a = 8'h00; p0.b = 8'hA5; p0.tag = 4'd6;
        p1.a = 8'h80; p1.b = 8'h80; p1.tag = 4'd7;
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive_pair(p0);
        @(negedge clk);
        drive_pair(p1);
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.out_pp !== '0 || bus.out_zero !== 1'b1 || bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL zero_a: got pp=%h z=%b v=%b want 0 1 1",
                     bus.out_pp, bus.out_zero, bus.out_valid);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_pp !== 64'h8000000000000000 || bus.out_zero !== 1'b0 ||
            bus.out_tag !== 4'd7) begin
            failures++;
            $display("FAIL zero_msb: got pp=%h z=%b tag=%h want 8000000000000000 0 7",
                     bus.out_pp, bus.out_zero, bus.out_tag);
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive_pair(rand_pair());
        @(negedge clk);
        drive_pair(rand_pair());
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_full: got rdy=%b v=%b want 0 1", bus.in_ready, bus.out_valid);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_in_ready: got %b want 0", bus.in_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_during: got v=%b rdy=%b want 0 0", bus.out_valid, bus.in_ready);
        end
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_after: got in_ready=%b want 1", bus.in_ready);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_stale: got out_valid=%b want 0 (cycle %0d)",
                         bus.out_valid, k);
            end
        end
        drive_idle();
    endtask

    task automatic test_idle();
        op_pair_t p;
        p.a = OP_W'($urandom_range(1, 255));
        p.b = OP_W'($urandom_range(1, 255));
        p.tag = TAG_DW'($urandom_range(1, 15));
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive_pair(p);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_tag !== p.tag) begin
            failures++;
            $display("FAIL idle_load: got v=%b tag=%h want 1 %h",
                     bus.out_valid, bus.out_tag, p.tag);
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
`ifdef PPGEN_ISOLATE_EN
            if (bus.out_valid !== 1'b0 || bus.out_pp !== '0 || bus.out_tag !== '0) begin
                failures++;
                $display("FAIL idle_isolate: got v=%b pp=%h tag=%h want 0 0 0",
                         bus.out_valid, bus.out_pp, bus.out_tag);
            end
`else
            if (bus.out_valid !== 1'b0 || bus.out_pp !== ref_pp(p.a, p.b) ||
                bus.out_tag !== p.tag) begin
                failures++;
                $display("FAIL idle_hold: got v=%b pp=%h tag=%h want 0 %h %h",
                         bus.out_valid, bus.out_pp, bus.out_tag, ref_pp(p.a, p.b), p.tag);
            end
`endif
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_flow(1'b1, 100, "stream");
        test_zero();
        test_flow(1'b0, 150, "random");
        test_reset_mid();
        test_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
